// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display peripheral: register offsets,
// digit/segment types and the active-low gfedcba decode table.
package seg7_pkg;

  localparam logic [7:0] DIG_HI_OFS = 8'd0;
  localparam logic [7:0] DIG_LO_OFS = 8'd1;
  localparam logic [7:0] CTRL_OFS   = 8'd2;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // Active-low gfedcba; bit 7 (DP) is supplied separately by the output stage.
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-nibble to active-low seven-segment pattern lookup.
module seg7_decoder
  import seg7_pkg::*;
(
  input  nibble_t nibble_i,
  output seg_t    seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg7_display.sv
// 4-digit multiplexed common-anode seven-segment bus peripheral at BASE_ADDR..+2.
// Define SEG7_READBACK_EN to make the registers readable over BUS_DATA.
module seg7_display
  import seg7_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hD0,
  parameter int unsigned REFRESH_CNT = 49_999
)(
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT
);

  localparam int CNT_W = (REFRESH_CNT < 1) ? 1 : $clog2(REFRESH_CNT + 1);

  logic [7:0]       ofs;
  logic             in_range;
  logic             wr_en;
  logic [7:0]       dig_hi_q, dig_lo_q, ctrl_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  nibble_t          nib;
  seg_t             seg;
  logic             blank;
  logic [3:0]       sel_d, sel_q;
  logic [7:0]       hex_d, hex_q;

  // Unsigned wrap of the subtraction keeps addresses below BASE_ADDR out of range.
  assign ofs      = BUS_ADDR - BASE_ADDR;
  assign in_range = (ofs < 8'd3);
  assign wr_en    = BUS_WE && in_range;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dig_hi_q <= '0;
      dig_lo_q <= '0;
      ctrl_q   <= '0;
    end else if (wr_en) begin
      case (ofs)
        DIG_HI_OFS: dig_hi_q <= BUS_DATA;
        DIG_LO_OFS: dig_lo_q <= BUS_DATA;
        CTRL_OFS:   ctrl_q   <= BUS_DATA;
        default:    ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_CNT)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    nib = '0;
    case (idx_q)
      2'd0: nib = dig_lo_q[3:0];
      2'd1: nib = dig_lo_q[7:4];
      2'd2: nib = dig_hi_q[3:0];
      2'd3: nib = dig_hi_q[7:4];
      default: nib = '0;
    endcase
  end

  seg7_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (seg)
  );

  // Anode and cathode are registered together so a digit change never ghosts.
  always_comb begin
    blank = ctrl_q[3'd4 + {1'b0, idx_q}];
    sel_d = ~(4'b0001 << idx_q);
    hex_d = {~ctrl_q[idx_q], seg};
    if (blank) begin
      sel_d = 4'hF;
      hex_d = 8'hFF;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sel_q <= 4'hF;
      hex_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      hex_q <= hex_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;
  assign HEX_OUT        = hex_q;

`ifdef SEG7_READBACK_EN
  logic       rd_en_q;
  logic [7:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    case (ofs)
      DIG_HI_OFS: rd_data_d = dig_hi_q;
      DIG_LO_OFS: rd_data_d = dig_lo_q;
      CTRL_OFS:   rd_data_d = ctrl_q;
      default:    rd_data_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_en_q   <= !BUS_WE && in_range;
      rd_data_q <= rd_data_d;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule

// File: tb/tb_seg7_display.sv
// Scoreboard bench for seg7_display: a behavioural model pushes the expected
// display outputs each clock edge and a negedge checker pops and compares them.
module tb_seg7_display;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;
  wire  [7:0] BUS_DATA;
  logic       tb_en = 1'b0;
  logic [7:0] tb_drv = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  assign BUS_DATA = tb_en ? tb_drv : 8'hzz;

  always #5 CLK = ~CLK;

  seg7_display #(.BASE_ADDR(8'hD0), .REFRESH_CNT(3)) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .BUS_DATA       (BUS_DATA),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_WE         (BUS_WE),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  m_hi = '0, m_lo = '0, m_ctrl = '0;
  int          m_cnt = 0, m_idx = 0;
  logic [11:0] exp_q [$];
  logic [11:0] popped;

  function automatic logic [11:0] model_out(input int idx, input logic [7:0] hi,
                                            input logic [7:0] lo, input logic [7:0] ctrl);
    logic [3:0] nib;
    logic [3:0] sel;
    logic [7:0] ent;
    case (idx)
      0:       nib = lo[3:0];
      1:       nib = lo[7:4];
      2:       nib = hi[3:0];
      default: nib = hi[7:4];
    endcase
    if (ctrl[4+idx]) return 12'hFFF;
    sel = 4'hF;
    sel[idx] = 1'b0;
    ent = SEG_TABLE[nib];
    return {sel, ~ctrl[idx], ent[6:0]};
  endfunction

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_ctrl <= '0;
      m_cnt  <= 0;
      m_idx  <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(m_idx, m_hi, m_lo, m_ctrl));
      if (BUS_WE) begin
        case (BUS_ADDR)
          8'hD0:   m_hi   <= BUS_DATA;
          8'hD1:   m_lo   <= BUS_DATA;
          8'hD2:   m_ctrl <= BUS_DATA;
          default: ;
        endcase
      end
      if (m_cnt == 3) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (RESETN && exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      check("sb_seg_select", {28'd0, SEG_SELECT_OUT}, {28'd0, popped[11:8]});
      check("sb_hex_out", {24'd0, HEX_OUT}, {24'd0, popped[7:0]});
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a; BUS_WE = 1'b1; tb_drv = d; tb_en = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0; tb_en = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

`ifdef SEG7_READBACK_EN
  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge CLK);
    BUS_ADDR = a; BUS_WE = 1'b0; tb_en = 1'b0;
    @(negedge CLK);
    check(tag, {24'd0, BUS_DATA}, {24'd0, exp});
  endtask
`endif

  initial begin
    bit found;
    // Reset state
    #1 RESETN = 1'b0;
    #1;
    check("reset_seg_select", {28'd0, SEG_SELECT_OUT}, 32'hF);
    check("reset_hex_out", {24'd0, HEX_OUT}, 32'hFF);
    idle(3);
    RESETN = 1'b1;
    @(negedge CLK);
    check("first_edge_seg", {28'd0, SEG_SELECT_OUT}, 32'hE);
    check("first_edge_hex", {24'd0, HEX_OUT}, 32'hC0);

    // Plain scan of all-zero digits
    idle(20);

    // Digit values
    bus_write(8'hD0, 8'h12);
    bus_write(8'hD1, 8'h34);
    idle(18);

    // Out-of-range writes are ignored
    bus_write(8'hD3, 8'hFF);
    bus_write(8'hCF, 8'hFF);
    idle(8);

    // DP on digit0, blank digit1
    bus_write(8'hD2, 8'h21);
    idle(18);
    bus_write(8'hD2, 8'h00);

    // Write landing on the edge where digit0 first reaches the outputs
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (m_idx == 0 && m_cnt == 0) begin
        found = 1'b1;
        break;
      end
    end
    check("wrap_sync_found", {31'd0, found}, 32'd1);
    BUS_ADDR = 8'hD1; BUS_WE = 1'b1; tb_drv = 8'hAF; tb_en = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0; tb_en = 1'b0; BUS_ADDR = 8'h00;
    check("wrap_old_seg", {28'd0, SEG_SELECT_OUT}, 32'hE);
    check("wrap_old_hex", {24'd0, HEX_OUT}, 32'h99);
    @(negedge CLK);
    check("wrap_new_hex", {24'd0, HEX_OUT}, 32'h8E);
    idle(10);

    // All digits blank, scan keeps running underneath
    bus_write(8'hD2, 8'hF0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("all_blank_seg", {28'd0, SEG_SELECT_OUT}, 32'hF);
    end
    bus_write(8'hD2, 8'h0F);
    idle(18);

    // Asynchronous reset mid-scan
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (m_idx == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("idx2_sync_found", {31'd0, found}, 32'd1);
    #1 RESETN = 1'b0;
    #1;
    check("midscan_rst_seg", {28'd0, SEG_SELECT_OUT}, 32'hF);
    check("midscan_rst_hex", {24'd0, HEX_OUT}, 32'hFF);
    idle(2);
    RESETN = 1'b1;
    @(negedge CLK);
    check("post_rst_seg", {28'd0, SEG_SELECT_OUT}, 32'hE);
    check("post_rst_hex", {24'd0, HEX_OUT}, 32'hC0);
    idle(16);

`ifdef SEG7_READBACK_EN
    bus_read(8'hD0, 8'h00, "rb_hi_after_rst");
    bus_read(8'hD1, 8'h00, "rb_lo_after_rst");
    bus_read(8'hD2, 8'h00, "rb_ctrl_after_rst");
    bus_write(8'hD0, 8'h5A);
    bus_read(8'hD0, 8'h5A, "rb_hi_5a");
    @(negedge CLK);
    check("rb_hi_held", {24'd0, BUS_DATA}, 32'h5A);
    BUS_ADDR = 8'hE0;
    @(negedge CLK);
    tb_drv = 8'h3C; tb_en = 1'b1;
    #1;
    check("rb_released_e0", {24'd0, BUS_DATA}, 32'h3C);
    tb_en = 1'b0;
    BUS_ADDR = 8'h00;
`else
    bus_write(8'hD0, 8'h5A);
    @(negedge CLK);
    BUS_ADDR = 8'hD0; BUS_WE = 1'b0;
    @(negedge CLK);
    tb_drv = 8'hA5; tb_en = 1'b1;
    #1;
    check("no_readback_bus_free", {24'd0, BUS_DATA}, 32'hA5);
    tb_en = 1'b0;
    BUS_ADDR = 8'h00;
`endif
    idle(8);
    check("sb_queue_drained", {31'd0, exp_q.size() <= 1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
